// File: rtl/matmul_drv_pkg.sv
// Shared types and default constants for the matmul host driver.
package matmul_drv_pkg;

    localparam int unsigned DEF_DWIDTH        = 8;
    localparam int unsigned DEF_AWIDTH        = 7;
    localparam int unsigned DEF_MAT_MUL_SIZE  = 4;
    localparam int unsigned WORD_W            = DEF_MAT_MUL_SIZE * DEF_DWIDTH;
    localparam int unsigned DEF_NUM_A_WORDS   = 8;
    localparam int unsigned DEF_NUM_B_WORDS   = 8;
    localparam int unsigned DEF_NUM_C_WORDS   = 8;
    localparam int unsigned DEF_RD_LAT        = 4;
    localparam int unsigned DEF_WR_ALIGN      = 2;
    localparam int unsigned WD_W              = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_WR_FLUSH,
        S_COMPUTE,
        S_READ,
        S_RD_FLUSH,
        S_FIN
    } drv_state_e;

    // One write beat travelling down the write-alignment line.
    typedef struct packed {
        logic              we_a;
        logic              we_b;
        logic [WORD_W-1:0] data;
    } wr_beat_t;

endpackage

// File: rtl/matmul_drv_delay.sv
// Fixed-depth shift register with async reset; used for write alignment and read tags.
module matmul_drv_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH < 1) begin : g_depth_err
        $error("matmul_drv_delay: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/matmul_host_driver.sv
// Host-side sequencer for the systolic matmul: loads A/B, runs compute, streams C back.
// Optional watchdog on the compute phase is enabled by defining MATMUL_DRV_TIMEOUT_EN.
module matmul_host_driver
    import matmul_drv_pkg::*;
#(
    parameter int unsigned DWIDTH       = DEF_DWIDTH,
    parameter int unsigned AWIDTH       = DEF_AWIDTH,
    parameter int unsigned MAT_MUL_SIZE = DEF_MAT_MUL_SIZE,
    parameter int unsigned NUM_A_WORDS  = DEF_NUM_A_WORDS,
    parameter int unsigned NUM_B_WORDS  = DEF_NUM_B_WORDS,
    parameter int unsigned NUM_C_WORDS  = DEF_NUM_C_WORDS,
    parameter int unsigned RD_LAT       = DEF_RD_LAT,
    parameter int unsigned WR_ALIGN     = DEF_WR_ALIGN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              enable_writing_to_mem,
    output logic              enable_reading_from_mem,
    output logic              we_a,
    output logic              we_b,
    output logic              we_c,
    output logic              start_mat_mul,
    output logic [AWIDTH-1:0] addr_pi,
    output logic [WORD_W-1:0] data_pi,
    input  logic              done_mat_mul,
    input  logic [WORD_W-1:0] data_from_out_mat
`ifdef MATMUL_DRV_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    if ((NUM_A_WORDS > (1 << AWIDTH)) || (NUM_B_WORDS > (1 << AWIDTH)) ||
        (NUM_C_WORDS > (1 << AWIDTH)) || ((RD_LAT + 2) > (1 << AWIDTH)) ||
        ((WR_ALIGN + 1) > (1 << AWIDTH)) || (MAT_MUL_SIZE * DWIDTH != WORD_W)) begin : g_param_err
        $error("matmul_host_driver: word counts or latencies exceed the address range");
    end

    drv_state_e        state, state_next;
    logic [AWIDTH-1:0] cnt, cnt_next;
    logic [AWIDTH-1:0] addr_next;
    wr_beat_t          wr_issue, wr_issue_next, wr_out;
    logic              rd_issue, rd_issue_next, rd_tag;
    logic              accept;
    logic              wd_fire;

    assign accept = in_valid && in_ready;

    // Next-state, counter and issue-stage decode.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        addr_next     = addr_pi;
        wr_issue_next = '0;
        rd_issue_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_start) begin
                    state_next = S_LOAD_A;
                    cnt_next   = '0;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                if (accept) begin
                    addr_next          = cnt;
                    wr_issue_next.we_a = (state == S_LOAD_A);
                    wr_issue_next.we_b = (state == S_LOAD_B);
                    wr_issue_next.data = in_data;
                    cnt_next           = cnt + AWIDTH'(1);
                    if (state == S_LOAD_A && cnt == AWIDTH'(NUM_A_WORDS - 1)) begin
                        state_next = S_LOAD_B;
                        cnt_next   = '0;
                    end else if (state == S_LOAD_B && cnt == AWIDTH'(NUM_B_WORDS - 1)) begin
                        state_next = S_WR_FLUSH;
                        cnt_next   = '0;
                    end
                end
            end
            S_WR_FLUSH: begin
                // Hold the write enable until the last delayed we_b has left the line.
                if (cnt == AWIDTH'(WR_ALIGN)) begin
                    state_next = S_COMPUTE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + AWIDTH'(1);
                end
            end
            S_COMPUTE: begin
                if (done_mat_mul || wd_fire) state_next = S_READ;
            end
            S_READ: begin
                addr_next     = cnt;
                rd_issue_next = 1'b1;
                if (cnt == AWIDTH'(NUM_C_WORDS - 1)) begin
                    state_next = S_RD_FLUSH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + AWIDTH'(1);
                end
            end
            S_RD_FLUSH: begin
                // Issue stage + RD_LAT read latency + output register must all drain.
                if (cnt == AWIDTH'(RD_LAT + 1)) begin
                    state_next = S_FIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + AWIDTH'(1);
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                   <= S_IDLE;
            cnt                     <= '0;
            addr_pi                 <= '0;
            wr_issue                <= '0;
            rd_issue                <= 1'b0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            in_ready                <= 1'b0;
            enable_writing_to_mem   <= 1'b0;
            enable_reading_from_mem <= 1'b0;
            start_mat_mul           <= 1'b0;
            we_c                    <= 1'b0;
            out_valid               <= 1'b0;
            out_data                <= '0;
        end else begin
            state                   <= state_next;
            cnt                     <= cnt_next;
            addr_pi                 <= addr_next;
            wr_issue                <= wr_issue_next;
            rd_issue                <= rd_issue_next;
            busy                    <= (state_next != S_IDLE);
            done                    <= (state_next == S_FIN);
            in_ready                <= (state_next == S_LOAD_A) || (state_next == S_LOAD_B);
            enable_writing_to_mem   <= (state_next == S_LOAD_A) || (state_next == S_LOAD_B) ||
                                       (state_next == S_WR_FLUSH);
            enable_reading_from_mem <= (state_next == S_READ) || (state_next == S_RD_FLUSH);
            start_mat_mul           <= (state_next == S_COMPUTE);
            we_c                    <= (state_next == S_COMPUTE);
            out_valid               <= rd_tag;
            out_data                <= rd_tag ? data_from_out_mat : '0;
        end
    end

    matmul_drv_delay #(.WIDTH($bits(wr_beat_t)), .DEPTH(WR_ALIGN)) u_wr_dly (
        .clk   (clk),
        .reset (reset),
        .d     (wr_issue),
        .q     (wr_out)
    );

    assign we_a    = wr_out.we_a;
    assign we_b    = wr_out.we_b;
    assign data_pi = wr_out.data;

    matmul_drv_delay #(.WIDTH(1), .DEPTH(RD_LAT)) u_rd_tag (
        .clk   (clk),
        .reset (reset),
        .d     (rd_issue),
        .q     (rd_tag)
    );

`ifdef MATMUL_DRV_TIMEOUT_EN
    logic [WD_W-1:0] wd;

    assign wd_fire = (state == S_COMPUTE) && (wd == '1) && !done_mat_mul;

    // Watchdog restarts on every COMPUTE entry; the error flag is sticky until the next run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd          <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd <= (state == S_COMPUTE && state_next == S_COMPUTE) ? wd + WD_W'(1) : '0;
            if (state == S_IDLE && cmd_start) timeout_err <= 1'b0;
            else if (wd_fire)                 timeout_err <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_host_driver.sv
// Randomized bench for matmul_host_driver with a behavioural matmul stand-in and scoreboard.
module tb_matmul_host_driver;

    localparam int RD_LAT   = 4;
    localparam int WR_ALIGN = 2;

    logic        clk, reset, cmd_start, busy, done, in_valid, in_ready;
    logic [31:0] in_data, out_data, data_pi, data_from_out_mat;
    logic        out_valid, enable_writing_to_mem, enable_reading_from_mem;
    logic        we_a, we_b, we_c, start_mat_mul, done_mat_mul;
    logic [6:0]  addr_pi;
`ifdef MATMUL_DRV_TIMEOUT_EN
    logic        timeout_err;
`endif

    matmul_host_driver dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_start               (cmd_start),
        .busy                    (busy),
        .done                    (done),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_data                 (in_data),
        .out_valid               (out_valid),
        .out_data                (out_data),
        .enable_writing_to_mem   (enable_writing_to_mem),
        .enable_reading_from_mem (enable_reading_from_mem),
        .we_a                    (we_a),
        .we_b                    (we_b),
        .we_c                    (we_c),
        .start_mat_mul           (start_mat_mul),
        .addr_pi                 (addr_pi),
        .data_pi                 (data_pi),
        .done_mat_mul            (done_mat_mul),
        .data_from_out_mat       (data_from_out_mat)
`ifdef MATMUL_DRV_TIMEOUT_EN
        ,
        .timeout_err             (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // 8x4 int8 A row times 4x4 int8 B (rows = B words 0..3), results truncated to int8.
    function automatic logic [31:0] mm_row(input logic [31:0] ar, input logic [31:0] b0,
                                           input logic [31:0] b1, input logic [31:0] b2,
                                           input logic [31:0] b3);
        logic [31:0] bw [4];
        logic [31:0] r;
        int          s;
        bw[0] = b0; bw[1] = b1; bw[2] = b2; bw[3] = b3;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int k = 0; k < 4; k++)
                s += int'($signed(ar[8*k +: 8])) * int'($signed(bw[k][8*j +: 8]));
            r[8*j +: 8] = 8'(s);
        end
        return r;
    endfunction

    // Matmul stand-in: BRAMs with address pipelines, compute delay, C readback.
    logic [31:0] a_mem [8];
    logic [31:0] b_mem [8];
    logic [31:0] c_mem [8];
    logic [6:0]  wr_pipe [WR_ALIGN];
    logic [6:0]  rd_pipe [RD_LAT];
    logic        done_r;
    int          cc;
    int          dly = 1;
    bit          done_pre = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            done_r <= 1'b0;
            cc     <= 0;
            for (int i = 0; i < WR_ALIGN; i++) wr_pipe[i] <= '0;
            for (int i = 0; i < RD_LAT; i++)   rd_pipe[i] <= '0;
        end else begin
            wr_pipe[0] <= addr_pi;
            for (int i = 1; i < WR_ALIGN; i++) wr_pipe[i] <= wr_pipe[i-1];
            rd_pipe[0] <= addr_pi;
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            if (we_a) a_mem[wr_pipe[WR_ALIGN-1][2:0]] <= data_pi;
            if (we_b) b_mem[wr_pipe[WR_ALIGN-1][2:0]] <= data_pi;
            if (start_mat_mul) begin
                cc     <= cc + 1;
                done_r <= (cc + 1 >= dly);
                for (int i = 0; i < 8; i++)
                    c_mem[i] <= mm_row(a_mem[i], b_mem[0], b_mem[1], b_mem[2], b_mem[3]);
            end else begin
                cc     <= 0;
                done_r <= 1'b0;
            end
        end
    end

    assign done_mat_mul      = done_r | (done_pre & start_mat_mul);
    assign data_from_out_mat = c_mem[rd_pipe[RD_LAT-1][2:0]];

    // Scoreboard state.
    logic [31:0] a_beats [8];
    logic [31:0] b_beats [8];
    logic [31:0] exp_c   [8];
    logic [6:0]  addr_hist [8];
    int  cyc = 0;
    bit  mon_en = 1'b0, in_run = 1'b0, prev_start = 1'b0;
    int  we_a_cnt, we_b_cnt, beats, done_cnt, done_cyc, last_beat_cyc;
    int  start_cyc, we_c_cyc, busy_low;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        for (int i = 0; i < 8; i++) addr_hist[i] = '0;
        forever begin
            @(negedge clk);
            for (int i = 7; i > 0; i--) addr_hist[i] = addr_hist[i-1];
            addr_hist[0] = addr_pi;
            if (mon_en) begin
                if (in_run && !busy) busy_low++;
                if (we_a) begin
                    if (we_a_cnt < 8) begin
                        check_eq("we_a_addr", 32'(addr_hist[WR_ALIGN]), we_a_cnt);
                        check_eq("we_a_data", data_pi, a_beats[we_a_cnt]);
                    end
                    we_a_cnt++;
                end
                if (we_b) begin
                    if (we_b_cnt < 8) begin
                        check_eq("we_b_addr", 32'(addr_hist[WR_ALIGN]), we_b_cnt);
                        check_eq("we_b_data", data_pi, b_beats[we_b_cnt]);
                    end
                    we_b_cnt++;
                end
                if (start_mat_mul) start_cyc++;
                if (we_c) we_c_cyc++;
                if (prev_start && !start_mat_mul)
                    check_eq("read_follows", 32'(enable_reading_from_mem), 1);
                if (out_valid) begin
                    if (beats < 8) check_eq("out_data", out_data, exp_c[beats]);
                    beats++;
                    last_beat_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    in_run   = 1'b0;
                end else if (busy) begin
                    in_run = 1'b1;
                end
            end
            prev_start = start_mat_mul;
        end
    end

    task automatic make_beats(input bit ident);
        for (int i = 0; i < 8; i++) begin
            a_beats[i] = ident ? 32'h0101_0101 * (i + 1) : $urandom;
            b_beats[i] = ident ? ((i < 4) ? (32'h1 << (8 * i)) : 32'h0) : $urandom;
        end
        for (int i = 0; i < 8; i++)
            exp_c[i] = mm_row(a_beats[i], b_beats[0], b_beats[1], b_beats[2], b_beats[3]);
    endtask

    // vmode: 0 = in_valid always, 1 = toggling, 2 = random gaps.
    task automatic do_run(input int vmode, input int dly_i, input bit pre_i, input bit poke,
                          input bit ident, input int exp_start, input int limit);
        int idx, guard;
        bit v, acc, poked;
        make_beats(ident);
        dly = dly_i; done_pre = pre_i;
        we_a_cnt = 0; we_b_cnt = 0; beats = 0; done_cnt = 0; done_cyc = 0; last_beat_cyc = 0;
        start_cyc = 0; we_c_cyc = 0; busy_low = 0; in_run = 1'b0;
        mon_en = 1'b1;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        idx = 0; guard = 0;
        while (idx < 16 && guard < 400) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = !v ? $urandom : (idx < 8) ? a_beats[idx % 8] : b_beats[idx % 8];
            acc = v && in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) idx++;
        end
        check_eq("load_beats", idx, 16);
        guard = 0; poked = 1'b0;
        while (done_cnt == 0 && guard < limit) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            if (poke && start_mat_mul && !poked) begin
                cmd_start = 1'b1;
                poked     = 1'b1;
            end else begin
                cmd_start = 1'b0;
            end
            @(posedge clk); #1;
            guard++;
        end
        cmd_start = 1'b0; in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_eq("beats", beats, 8);
        check_eq("we_a_cnt", we_a_cnt, 8);
        check_eq("we_b_cnt", we_b_cnt, 8);
        check_eq("done_cnt", done_cnt, 1);
        check_eq("done_gap", done_cyc - last_beat_cyc, 1);
        check_eq("busy_gap", busy_low, 0);
        check_eq("idle_busy", 32'(busy), 0);
        if (exp_start >= 0) begin
            check_eq("start_len", start_cyc, exp_start);
            check_eq("we_c_len", we_c_cyc, exp_start);
        end
        mon_en = 1'b0;
    endtask

    task automatic do_abort();
        int idx, guard, n;
        bit acc;
        make_beats(1'b0);
        mon_en = 1'b0;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        idx = 0; guard = 0;
        while (idx < 12 && guard < 100) begin
            in_valid = 1'b1;
            in_data  = (idx < 8) ? a_beats[idx % 8] : b_beats[idx % 8];
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) idx++;
        end
        check_eq("abort_loaded", idx, 12);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("abort_ctl", 32'({busy, done, in_ready, out_valid, enable_writing_to_mem,
                                   enable_reading_from_mem, we_a, we_b, we_c, start_mat_mul}), 0);
        check_eq("abort_addr", 32'(addr_pi), 0);
        check_eq("abort_data", data_pi, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (we_a || we_b || busy) n++;
        end
        check_eq("abort_quiet", n, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; cmd_start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ctl", 32'({busy, done, in_ready, out_valid, enable_writing_to_mem,
                                 enable_reading_from_mem, we_a, we_b, we_c, start_mat_mul}), 0);
        check_eq("rst_addr", 32'(addr_pi), 0);
        check_eq("rst_data", data_pi, 0);
        check_eq("rst_out", out_data, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_ready", 32'(in_ready), 0);

        do_run(0, 3,   1'b0, 1'b0, 1'b1, 4,   2000);
        do_run(1, 0,   1'b1, 1'b0, 1'b0, 1,   2000);
        do_run(2, 500, 1'b0, 1'b0, 1'b0, 501, 2000);
        do_abort();
        do_run(2, 5,   1'b0, 1'b1, 1'b0, 6,   2000);
`ifdef MATMUL_DRV_TIMEOUT_EN
        do_run(0, 1000000, 1'b0, 1'b0, 1'b0, -1, 70000);
        check_eq("timeout_set", 32'(timeout_err), 1);
        do_run(0, 2, 1'b0, 1'b0, 1'b0, 3, 2000);
        check_eq("timeout_clr", 32'(timeout_err), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
